// File: rtl/tpuv2.sv
`default_nettype none
// ============================================================================
// Module      : tpuv2
// Description : Memory-mapped DIM x DIM output-stationary matrix-multiply unit.
//               Computes C = A x B (ACC=0, hardware clear pass first) or
//               C += A x B (ACC=1). Operand stores, the systolic core, the
//               C read/modify/write path and a busy/done status register all
//               live on a single-master r_w/addr/dataIn/dataOut bus.
// Ports       : clk     - clock
//               rst_n   - asynchronous active-low reset
//               r_w     - 1 = write strobe this cycle, 0 = read
//               dataIn  - write data (DATAW)
//               dataOut - read data, combinational from addr (DATAW)
//               addr    - byte address (ADDRW)
//               busy    - clear or compute pass in progress
//               done    - sticky completion flag
// Address map : addr[11:8] region, addr[7:3] word index.
//               0x1 W A row | 0x2 W push B row | 0x3 R/W C segment
//               0x4 W start (dataIn[0]=ACC) | 0x5 R {done,busy}, W dataIn[0] clears done
// Legality    : DATAW == DIM*BITS_AB; DIM*BITS_C a power-of-2 multiple of DATAW.
// Revision    : 1.0 - initial release
// ============================================================================
module tpuv2 #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r_w,
  input  logic [DATAW-1:0] dataIn,
  output logic [DATAW-1:0] dataOut,
  input  logic [ADDRW-1:0] addr,
  output logic             busy,
  output logic             done
);

  localparam int C_WORDS = DIM * BITS_C / DATAW;
  localparam int C_LANES = DATAW / BITS_C;
  localparam int LOG2DIM = $clog2(DIM);
  localparam int SEGW    = (C_WORDS > 1) ? $clog2(C_WORDS) : 1;
  localparam int CNTW    = $clog2(3 * DIM);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  localparam logic [CNTW-1:0] CLEAR_LAST = CNTW'(DIM - 1);
  localparam logic [CNTW-1:0] RUN_LAST   = CNTW'(3 * DIM - 2);

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [3:0]         w_region;
  logic [4:0]         w_idx;
  logic [LOG2DIM-1:0] w_c_row;
  logic [SEGW-1:0]    w_seg;
  logic               w_unused;

  assign w_region = addr[11:8];
  assign w_idx    = addr[7:3];
  assign w_c_row  = LOG2DIM'(int'(w_idx) / C_WORDS);
  assign w_seg    = SEGW'(int'(w_idx) % C_WORDS);
  assign w_unused = ^{addr[2:0], addr[ADDRW-1:12]};

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  logic [1:0]      r_state;
  logic [CNTW-1:0] r_cnt;
  logic            r_busy;
  logic            r_done;

  logic w_wr_ok;
  logic w_start;
  logic w_en;
  logic w_clear;
  logic w_done_set;
  logic w_done_clr;

  // r_busy mirrors (r_state != IDLE), so it doubles as the operand lock-out.
  assign w_wr_ok    = r_w && !r_busy;
  assign w_start    = w_wr_ok && (w_region == 4'h4);
  assign w_en       = (r_state == RUN);
  assign w_clear    = (r_state == CLEAR);
  assign w_done_set = w_en && (r_cnt == RUN_LAST);
  assign w_done_clr = r_w && (w_region == 4'h5) && dataIn[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= dataIn[0] ? RUN : CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (r_cnt == CLEAR_LAST) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        RUN: begin
          if (r_cnt == RUN_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Completion has priority over a same-cycle done-clear write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else if (w_done_set) begin
      r_done <= 1'b1;
    end else if (w_start || w_done_clr) begin
      r_done <= 1'b0;
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  // --------------------------------------------------------------------------
  // Operand stores: A is row-addressed, B is a row shift queue whose oldest
  // of the last DIM pushes sits in row 0.
  // --------------------------------------------------------------------------
  logic signed [BITS_AB-1:0] r_a [DIM][DIM];
  logic signed [BITS_AB-1:0] r_b [DIM][DIM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++)
        for (int k = 0; k < DIM; k++)
          r_a[i][k] <= '0;
    end else if (w_wr_ok && (w_region == 4'h1)) begin
      for (int k = 0; k < DIM; k++)
        r_a[w_idx[LOG2DIM-1:0]][k] <= dataIn[k*BITS_AB +: BITS_AB];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++)
        for (int k = 0; k < DIM; k++)
          r_b[r][k] <= '0;
    end else if (w_wr_ok && (w_region == 4'h2)) begin
      for (int r = 0; r < DIM - 1; r++)
        for (int k = 0; k < DIM; k++)
          r_b[r][k] <= r_b[r+1][k];
      for (int k = 0; k < DIM; k++)
        r_b[DIM-1][k] <= dataIn[k*BITS_AB +: BITS_AB];
    end
  end

  // --------------------------------------------------------------------------
  // Skewed edge feed: at RUN count t, row i of A presents A[i][t-i] and
  // column j of B presents B[t-j][j], zero outside 0..DIM-1. The unsigned
  // offset wraps far above DIM when t < i, so one compare covers both ends.
  // --------------------------------------------------------------------------
  logic signed [BITS_AB-1:0] w_feed_a [DIM];
  logic signed [BITS_AB-1:0] w_feed_b [DIM];

  for (genvar i = 0; i < DIM; i++) begin : g_feed
    logic [CNTW-1:0] w_off;
    assign w_off       = r_cnt - CNTW'(i);
    assign w_feed_a[i] = (w_off < CNTW'(DIM)) ? r_a[i][LOG2DIM'(w_off)] : '0;
    assign w_feed_b[i] = (w_off < CNTW'(DIM)) ? r_b[LOG2DIM'(w_off)][i] : '0;
  end

  // --------------------------------------------------------------------------
  // Systolic core: A flows right, B flows down, each PE keeps its C.
  // --------------------------------------------------------------------------
  logic signed [BITS_AB-1:0] r_pa     [DIM][DIM];
  logic signed [BITS_AB-1:0] r_pb     [DIM][DIM];
  logic signed [BITS_C-1:0]  r_c      [DIM][DIM];
  logic signed [BITS_AB-1:0] w_a_in   [DIM][DIM];
  logic signed [BITS_AB-1:0] w_b_in   [DIM][DIM];
  logic signed [BITS_C-1:0]  w_prod   [DIM][DIM];

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign w_a_in[i][j] = w_feed_a[i];
      end else begin : g_a_inner
        assign w_a_in[i][j] = r_pa[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign w_b_in[i][j] = w_feed_b[j];
      end else begin : g_b_inner
        assign w_b_in[i][j] = r_pb[i-1][j];
      end
      // Sign-extend before multiplying; the sum wraps in BITS_C.
      assign w_prod[i][j] = BITS_C'(w_a_in[i][j]) * BITS_C'(w_b_in[i][j]);
    end
  end

  // --------------------------------------------------------------------------
  // C row write port: the clear pass writes zero rows, an idle C write merges
  // one segment of dataIn into the current row.
  // --------------------------------------------------------------------------
  logic                     w_c_we;
  logic [LOG2DIM-1:0]       w_c_sel;
  logic signed [BITS_C-1:0] w_cin [DIM];

  assign w_c_we  = w_clear || (w_wr_ok && (w_region == 4'h3));
  assign w_c_sel = w_clear ? LOG2DIM'(r_cnt) : w_c_row;

  for (genvar j = 0; j < DIM; j++) begin : g_cin
    assign w_cin[j] = w_clear ? '0 :
                      (w_seg == SEGW'(j / C_LANES)) ? dataIn[(j % C_LANES)*BITS_C +: BITS_C] :
                      r_c[w_c_row][j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          r_pa[i][j] <= '0;
          r_pb[i][j] <= '0;
          r_c[i][j]  <= '0;
        end
    end else begin
      if (w_en) begin
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++) begin
            r_pa[i][j] <= w_a_in[i][j];
            r_pb[i][j] <= w_b_in[i][j];
            r_c[i][j]  <= r_c[i][j] + w_prod[i][j];
          end
      end
      // Never concurrent with w_en: CLEAR and RUN are exclusive, and idle
      // writes are blocked while busy.
      if (w_c_we) begin
        for (int j = 0; j < DIM; j++)
          r_c[w_c_sel][j] <= w_cin[j];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    dataOut = '0;
    case (w_region)
      4'h3: begin
        for (int j = 0; j < C_LANES; j++)
          dataOut[j*BITS_C +: BITS_C] = r_c[w_c_row][LOG2DIM'(int'(w_seg) * C_LANES + j)];
      end
      4'h5: dataOut[1:0] = {r_done, r_busy};
      default: dataOut = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/tpuv2.md
Name: tpuv2

Overview:
- Second-generation memory-mapped matrix-multiply unit. Computes C = A×B, or C += A×B, on a DIM×DIM output-stationary systolic core.
- Reuses the existing systolic_array, memA and memB blocks.
- Adds fully parametrised word/row mapping, a hardware C-clear pass, a busy/done status register, a done-clear command and busy lock-out of operand writes.
- Sits on the same single-master r_w/addr/dataIn/dataOut bus as the current TPU.

Parameters:
- BITS_AB, 8: A/B element width (signed).
- BITS_C, 16: C element width (signed).
- DIM, 8: array dimension; power of 2, 2..32.
- ADDRW, 16: address width.
- DATAW, 64: bus width.
- Legality: DATAW must equal DIM*BITS_AB, and DIM*BITS_C must be a power-of-2 multiple of DATAW.
- Derived: C_WORDS = DIM*BITS_C/DATAW; C_LANES = DATAW/BITS_C.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- r_w, input, 1: 1 = write strobe this cycle, 0 = read.
- dataIn, input, DATAW: write data.
- dataOut, output, DATAW: read data (combinational from addr).
- addr, input, ADDRW: byte address.
- busy, output, 1: clear or compute in progress.
- done, output, 1: sticky completion flag.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Decode: region = addr[11:8]; word index w = addr[7:3]; addr[2:0] and addr[ADDRW-1:12] are ignored.
- Region 0x1, write: memA row w[log2 DIM-1:0] <= dataIn. Element k is dataIn[k*BITS_AB +: BITS_AB].
- Region 0x2, write: push dataIn into memB with the same element slicing.
- Region 0x3, C access:
  - Row = w / C_WORDS; segment s = w % C_WORDS.
  - Read: dataOut = elements s*C_LANES .. s*C_LANES+C_LANES-1 of that row; lane j is dataOut[j*BITS_C +: BITS_C].
  - Write: read-modify-write. Cin = current Cout row with only segment s replaced from dataIn, WrEn asserted, same cycle.
- Region 0x4, write: start. dataIn[0] = ACC; 1 = accumulate onto existing C, 0 = clear C first.
- Region 0x5:
  - Read: dataOut = {zeros, done, busy} (bit1 = done, bit0 = busy).
  - Write with dataIn[0] = 1: clear done.
- Reads of regions other than 0x3/0x5 return 0.
- While busy, writes to regions 0x1/0x2/0x3/0x4 are ignored. C reads return the live Cout and are undefined mid-run.
- FSM states: IDLE, CLEAR, RUN.
  - IDLE, start with ACC=0: go to CLEAR, cnt=0.
  - IDLE, start with ACC=1: go to RUN, cnt=0.
  - CLEAR: for DIM cycles drive Crow = cnt, Cin = 0, WrEn = 1. After cnt = DIM-1, go to RUN with cnt=0.
  - RUN: en is high for exactly 3*DIM-1 cycles (cnt 0..3*DIM-2). On cnt = 3*DIM-2, go to IDLE, set done, cnt=0.
  - cnt width is $clog2(3*DIM), so it never wraps early.
- busy = (state != IDLE), registered with the state. It rises the cycle after the start write.
- Any start accepted from IDLE also clears done.
- Done set and a done-clear write in the same cycle: set wins.
- Core en is only high in RUN; WrEn is only from CLEAR or a legal idle C write.
- Reset (any time, including mid-CLEAR/RUN): state = IDLE, cnt = 0, busy = 0, done = 0, en = 0. Sub-block contents follow their own reset. dataOut is a pure function of addr and array contents.
- Latency: ACC=0 start-to-done is DIM + 3*DIM - 1 + 1 cycles = 32 at DIM=8; ACC=1 is 24.

Test Plan:
- Reset: assert rst_n=0 mid-RUN → busy=0, done=0, status read (addr 0x500) = 0x0; a following start runs normally.
- Identity multiply: DIM=8, A = identity, B row i = all (i+1), start with dataIn=0 → busy for 31 cycles, then done=1. Read 0x300+16*i → every lane = i+1; read 0x308+16*i → every lane = i+1.
- Accumulate: repeat the identity run with dataIn=1 at 0x400 → C row i lanes = 2*(i+1); done re-asserts after 24 cycles.
- C read-modify-write: idle, write 0x318 with dataIn = 0x0004_0003_0002_0001 → row 1 lanes 4..7 = 1,2,3,4; lanes 0..3 unchanged; other rows unchanged.
- Busy lock-out: during RUN, write A row 0 = 0x7F.., issue start again, write C → after done, A/C show no corruption and exactly one run occurred (cycle count matches).
- Done handling: done=1, write 0x500 with dataIn=1 on the completion cycle of a second run → done stays 1. A later clear write → done=0.
